multicycle_control_unit: RTL and testbench

- Main control FSM for the multi-cycle RISC-V datapath.
- Decodes the 7-bit opcode and sequences FETCH/DECODE/execute/writeback states.
- Drives datapath mux selects, memory strobes and write enables.
- Generates the 3-bit ALU_Op consumed downstream by ALU_Control: 000 R-type, 001 I-type ALU, 010 forced add, 011 branch compare, 100 LUI.
- Memory accesses use a ready handshake, so a fetch or access may stall for any number of cycles.

---
 rtl/multicycle_control_unit_if.sv | 41 ++++
 rtl/multicycle_control_unit.sv | 174 +++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// Control-unit boundary: datapath status in, datapath controls out.
// Shared by the control FSM (master) and the datapath (slave).
interface multicycle_control_unit_if #(
  parameter int CNT_WIDTH = 32
);
  logic [6:0]           opcode_i;
  logic                 zero_i;
  logic                 mem_ready_i;
  logic                 pc_write_o;
  logic                 ir_write_o;
  logic                 adr_src_o;
  logic                 mem_read_o;
  logic                 mem_write_o;
  logic                 reg_write_o;
  logic [1:0]           alu_src_a_o;
  logic [1:0]           alu_src_b_o;
  logic [1:0]           result_src_o;
  logic [2:0]           ALU_Op_o;
  logic                 branch_o;
  logic                 illegal_instr_o;
  logic [CNT_WIDTH-1:0] retired_cnt_o;
  logic [3:0]           state_o;

  modport master (
    input  opcode_i, zero_i, mem_ready_i,
    output pc_write_o, ir_write_o, adr_src_o,
    output mem_read_o, mem_write_o, reg_write_o,
    output alu_src_a_o, alu_src_b_o, result_src_o,
    output ALU_Op_o, branch_o, illegal_instr_o,
    output retired_cnt_o, state_o
  );

  modport slave (
    output opcode_i, zero_i, mem_ready_i,
    input  pc_write_o, ir_write_o, adr_src_o,
    input  mem_read_o, mem_write_o, reg_write_o,
    input  alu_src_a_o, alu_src_b_o, result_src_o,
    input  ALU_Op_o, branch_o, illegal_instr_o,
    input  retired_cnt_o, state_o
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Main control FSM of the multi-cycle RISC-V datapath.
// Sequences fetch/decode/execute/writeback and counts retired instructions.
module multicycle_control_unit #(
  parameter int CNT_WIDTH = 32
) (
  input  logic clk,
  input  logic reset,
  multicycle_control_unit_if.master bus
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R    = 4'd6;
  localparam logic [3:0] S_EXEC_I    = 4'd7;
  localparam logic [3:0] S_ALU_WB    = 4'd8;
  localparam logic [3:0] S_BRANCH    = 4'd9;
  localparam logic [3:0] S_JAL       = 4'd10;
  localparam logic [3:0] S_LUI       = 4'd11;

  logic [3:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic       rdy;
  logic       op_r, op_i, op_ld, op_st;
  logic       op_br, op_jal, op_lui;
  logic       pc_update, branch, ir_write;
  logic       adr_src, mem_read, mem_write;
  logic       reg_write, illegal, retire;
  logic [1:0] src_a, src_b, res_src;
  logic [2:0] alu_op;

  assign rdy = bus.mem_ready_i;

  always_comb begin
    op_r   = bus.opcode_i == 7'b0110011;
    op_i   = bus.opcode_i == 7'b0010011;
    op_ld  = bus.opcode_i == 7'b0000011;
    op_st  = bus.opcode_i == 7'b0100011;
    op_br  = bus.opcode_i == 7'b1100011;
    op_jal = bus.opcode_i == 7'b1101111;
    op_lui = bus.opcode_i == 7'b0110111;
  end

  always_comb begin
    state_d   = S_FETCH;
    pc_update = 1'b0;
    branch    = 1'b0;
    ir_write  = 1'b0;
    adr_src   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    illegal   = 1'b0;
    retire    = 1'b0;
    src_a     = 2'b00;
    src_b     = 2'b00;
    res_src   = 2'b00;
    alu_op    = 3'b000;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        src_b     = 2'b10;
        alu_op    = 3'b010;
        res_src   = 2'b10;
        ir_write  = rdy;
        pc_update = rdy;
        state_d   = rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        src_a  = 2'b01;
        src_b  = 2'b01;
        alu_op = 3'b010;
        unique case (1'b1)
          op_r:          state_d = S_EXEC_R;
          op_i:          state_d = S_EXEC_I;
          op_ld, op_st:  state_d = S_MEM_ADDR;
          op_br:         state_d = S_BRANCH;
          op_jal:        state_d = S_JAL;
          op_lui:        state_d = S_LUI;
          default:       illegal = 1'b1;
        endcase
      end
      S_MEM_ADDR: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        alu_op  = 3'b010;
        state_d = op_ld ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        adr_src  = 1'b1;
        mem_read = 1'b1;
        state_d  = rdy ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        res_src   = 2'b01;
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_MEM_WRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        retire    = rdy;
        state_d   = rdy ? S_FETCH : S_MEM_WRITE;
      end
      S_EXEC_R: begin
        src_a   = 2'b10;
        state_d = S_ALU_WB;
      end
      S_EXEC_I: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        alu_op  = 3'b001;
        state_d = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        src_a  = 2'b10;
        alu_op = 3'b011;
        branch = 1'b1;
        retire = 1'b1;
      end
      // Link value old PC+4 goes to ALUOut; ALU_WB writes it to rd.
      S_JAL: begin
        src_a     = 2'b01;
        src_b     = 2'b10;
        alu_op    = 3'b010;
        pc_update = 1'b1;
        state_d   = S_ALU_WB;
      end
      S_LUI: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        alu_op  = 3'b100;
        state_d = S_ALU_WB;
      end
      default: state_d = S_FETCH;
    endcase
    cnt_d = retire ? cnt_q + CNT_WIDTH'(1) : cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Controls are forced quiet while reset is held.
  assign bus.pc_write_o      = ~reset & (pc_update | (branch & bus.zero_i));
  assign bus.ir_write_o      = ~reset & ir_write;
  assign bus.adr_src_o       = ~reset & adr_src;
  assign bus.mem_read_o      = ~reset & mem_read;
  assign bus.mem_write_o     = ~reset & mem_write;
  assign bus.reg_write_o     = ~reset & reg_write;
  assign bus.alu_src_a_o     = reset ? 2'b00 : src_a;
  assign bus.alu_src_b_o     = reset ? 2'b00 : src_b;
  assign bus.result_src_o    = reset ? 2'b00 : res_src;
  assign bus.ALU_Op_o        = reset ? 3'b000 : alu_op;
  assign bus.branch_o        = ~reset & branch;
  assign bus.illegal_instr_o = ~reset & illegal;
  assign bus.retired_cnt_o   = cnt_q;
  assign bus.state_o         = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit against an instruction-level model.
// Runs a 32-bit and a 4-bit counter instance in lockstep.
module tb_multicycle_control_unit;

  logic       clk;
  logic       reset;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;

  int checks = 0;
  int failures = 0;
  int model_cnt = 0;

  multicycle_control_unit_if #(.CNT_WIDTH(32)) b32 ();
  multicycle_control_unit_if #(.CNT_WIDTH(4))  b4 ();

  assign b32.opcode_i    = opcode;
  assign b32.zero_i      = zero;
  assign b32.mem_ready_i = mem_ready;
  assign b4.opcode_i     = opcode;
  assign b4.zero_i       = zero;
  assign b4.mem_ready_i  = mem_ready;

  multicycle_control_unit #(.CNT_WIDTH(32)) dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (b32)
  );

  multicycle_control_unit #(.CNT_WIDTH(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (b4)
  );

  logic [16:0] v32, v4;
  assign v32 = {b32.pc_write_o, b32.ir_write_o, b32.adr_src_o,
                b32.mem_read_o, b32.mem_write_o, b32.reg_write_o,
                b32.alu_src_a_o, b32.alu_src_b_o, b32.result_src_o,
                b32.ALU_Op_o, b32.branch_o, b32.illegal_instr_o};
  assign v4  = {b4.pc_write_o, b4.ir_write_o, b4.adr_src_o,
                b4.mem_read_o, b4.mem_write_o, b4.reg_write_o,
                b4.alu_src_a_o, b4.alu_src_b_o, b4.result_src_o,
                b4.ALU_Op_o, b4.branch_o, b4.illegal_instr_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Control word each state should present, taken from the state table.
  function automatic logic [16:0] exp_vec(int st, bit rdy, bit z, bit ill);
    logic pcw, irw, adr, mrd, mwr, rgw, br;
    logic [1:0] a, b, rs;
    logic [2:0] op;
    {pcw, irw, adr, mrd, mwr, rgw, br} = '0;
    a = 0; b = 0; rs = 0; op = 0;
    case (st)
      0:  begin mrd = 1; b = 2; op = 2; rs = 2; irw = rdy; pcw = rdy; end
      1:  begin a = 1; b = 1; op = 2; end
      2:  begin a = 2; b = 1; op = 2; end
      3:  begin adr = 1; mrd = 1; end
      4:  begin rs = 1; rgw = 1; end
      5:  begin adr = 1; mwr = 1; end
      6:  begin a = 2; b = 0; op = 0; end
      7:  begin a = 2; b = 1; op = 1; end
      8:  begin rgw = 1; end
      9:  begin a = 2; op = 3; br = 1; pcw = z; end
      10: begin a = 1; b = 2; op = 2; pcw = 1; end
      11: begin a = 2; b = 1; op = 4; end
      default: ;
    endcase
    return {pcw, irw, adr, mrd, mwr, rgw, a, b, rs, op, br, ill};
  endfunction

  task automatic do_cycle(input int st, input bit rdy, input bit ill);
    mem_ready = rdy;
    @(negedge clk);
    check("state", 32'(b32.state_o), 32'(st));
    check("ctrl32", 32'(v32), 32'(exp_vec(st, rdy, zero, ill)));
    check("ctrl4", 32'(v4), 32'(exp_vec(st, rdy, zero, ill)));
    check("cnt32", b32.retired_cnt_o, 32'(model_cnt));
    check("cnt4", 32'(b4.retired_cnt_o), 32'(model_cnt % 16));
    @(posedge clk);
    #1;
  endtask

  function automatic bit rnd();
    return bit'($urandom_range(0, 1));
  endfunction

  // One instruction: expected state walk derived from its opcode class.
  task automatic run_instr(input logic [6:0] op, input bit z,
                           input int fs, input int ms);
    bit ill;
    opcode = op;
    zero   = z;
    ill    = 1'b0;
    for (int i = 0; i < fs; i++) do_cycle(0, 0, 0);
    do_cycle(0, 1, 0);
    case (op)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
      7'b1100011, 7'b1101111, 7'b0110111: ill = 1'b0;
      default: ill = 1'b1;
    endcase
    do_cycle(1, rnd(), ill);
    case (op)
      7'b0110011: begin do_cycle(6, rnd(), 0); do_cycle(8, rnd(), 0); end
      7'b0010011: begin do_cycle(7, rnd(), 0); do_cycle(8, rnd(), 0); end
      7'b0000011: begin
        do_cycle(2, rnd(), 0);
        for (int i = 0; i < ms; i++) do_cycle(3, 0, 0);
        do_cycle(3, 1, 0);
        do_cycle(4, rnd(), 0);
      end
      7'b0100011: begin
        do_cycle(2, rnd(), 0);
        for (int i = 0; i < ms; i++) do_cycle(5, 0, 0);
        do_cycle(5, 1, 0);
      end
      7'b1100011: do_cycle(9, rnd(), 0);
      7'b1101111: begin do_cycle(10, rnd(), 0); do_cycle(8, rnd(), 0); end
      7'b0110111: begin do_cycle(11, rnd(), 0); do_cycle(8, rnd(), 0); end
      default: ;
    endcase
    if (!ill) model_cnt++;
  endtask

  logic [6:0] legal_ops [7];
  logic [6:0] op_pick;

  initial begin
    legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                  7'b1100011, 7'b1101111, 7'b0110111};
    reset     = 1'b1;
    opcode    = 7'b0110011;
    zero      = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(b32.state_o), 32'd0);
    check("rst_ctrl", 32'(v32), 32'd0);
    check("rst_cnt", b32.retired_cnt_o, 32'd0);
    reset = 1'b0;

    run_instr(7'b0110011, 0, 0, 0);
    // Abandon an R-type in EXEC_R with an async reset between edges.
    opcode = 7'b0110011;
    do_cycle(0, 1, 0);
    do_cycle(1, 0, 0);
    #3 reset = 1'b1;
    #1;
    check("async_state", 32'(b32.state_o), 32'd0);
    check("async_ctrl", 32'(v32), 32'd0);
    check("async_cnt", b32.retired_cnt_o, 32'd0);
    check("async_cnt4", 32'(b4.retired_cnt_o), 32'd0);
    model_cnt = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_instr(7'b0110011, 0, 0, 0);
    run_instr(7'b0000011, 0, 0, 3);
    run_instr(7'b0100011, 1, 2, 2);
    run_instr(7'b1100011, 1, 0, 0);
    run_instr(7'b1100011, 0, 1, 0);
    run_instr(7'b1111111, 0, 0, 0);
    run_instr(7'b1101111, 0, 0, 0);
    run_instr(7'b0010011, 0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) op_pick = 7'($urandom);
      else op_pick = legal_ops[$urandom_range(0, 6)];
      run_instr(op_pick, rnd(), $urandom_range(0, 3), $urandom_range(0, 4));
    end

    for (int n = 0; n < 16; n++) run_instr(7'b0110111, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
